// File: rtl/otter_io_pkg.sv
// Shared constants and types for the OTTER IO/interrupt peripheral.
package otter_io_pkg;

    localparam logic [31:0] BASE_ADDR_DEF = 32'h11000000;

    // Word offsets (IOBUS_ADDR[4:2]) inside the 32-byte register window
    localparam logic [2:0] OFF_STATUS = 3'd0;
    localparam logic [2:0] OFF_COUNT  = 3'd1;
    localparam logic [2:0] OFF_MASK   = 3'd2;
    localparam logic [2:0] OFF_SWITCH = 3'd3;
    localparam logic [2:0] OFF_LEDS   = 3'd4;

    typedef enum logic [1:0] {LOW, RISE_WAIT, HIGH, FALL_WAIT} db_state_t;

endpackage

// File: rtl/otter_intr_ctrl_if.sv
// OTTER IOBUS bundle: MCU drives address/data/strobe, peripheral returns read data.
interface otter_intr_ctrl_if;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;

    modport master (output IOBUS_ADDR, IOBUS_OUT, IOBUS_WR, input IOBUS_IN);
    modport slave  (input IOBUS_ADDR, IOBUS_OUT, IOBUS_WR, output IOBUS_IN);
endinterface

// File: rtl/io_debounce.sv
// Button synchroniser + debounce FSM; emits a one-cycle registered event on a
// qualified low->high transition only.
module io_debounce
    import otter_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic evt
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1, s;
    db_state_t     state;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser for the raw asynchronous button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s  <= 1'b0;
        end else begin
            s1 <= btn;
            s  <= s1;
        end
    end

    // Debounce FSM: a level must hold DEBOUNCE_CYCLES synced cycles to be accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOW;
            cnt   <= '0;
            evt   <= 1'b0;
        end else begin
            evt <= 1'b0;
            case (state)
                LOW: if (s) begin
                    state <= RISE_WAIT;
                    cnt   <= CW'(1);
                end
                RISE_WAIT: if (!s) begin
                    state <= LOW;
                    cnt   <= '0;
                end else if (cnt == CNT_LAST) begin
                    state <= HIGH;
                    cnt   <= '0;
                    evt   <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                HIGH: if (!s) begin
                    state <= FALL_WAIT;
                    cnt   <= CW'(1);
                end
                FALL_WAIT: if (s) begin
                    state <= HIGH;
                    cnt   <= '0;
                end else if (cnt == CNT_LAST) begin
                    state <= LOW;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                default: begin
                    state <= LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/otter_intr_ctrl.sv
// OTTER memory-mapped interrupt/IO peripheral: register file, address decode,
// read mux and INTR generation around a debounced button.
// Optional macro INTR_ONESHOT_EN: INTR becomes a one-cycle pulse instead of a level.
module otter_intr_ctrl
    import otter_io_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter logic [31:0] BASE_ADDR       = BASE_ADDR_DEF
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               BTN,
    input  logic [15:0]        SW,
    otter_intr_ctrl_if.slave   iobus,
    output logic               INTR,
    output logic [15:0]        LEDS
);
    logic        evt;
    logic        pending, mask;
    logic [15:0] count;

    logic        hit, wr;
    logic [2:0]  off;
    logic        ack, cnt_clr, mask_wr, leds_wr;
    logic        pending_n, mask_n;

    io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk (clk),
        .rst (RST),
        .btn (BTN),
        .evt (evt)
    );

    assign hit     = (iobus.IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
    assign off     = iobus.IOBUS_ADDR[4:2];
    assign wr      = iobus.IOBUS_WR & hit;
    assign ack     = wr && (off == OFF_STATUS) && iobus.IOBUS_OUT[0];
    assign cnt_clr = wr && (off == OFF_COUNT);
    assign mask_wr = wr && (off == OFF_MASK);
    assign leds_wr = wr && (off == OFF_LEDS);

    // A new event beats a same-cycle ack so no press is ever lost
    assign pending_n = evt | (pending & ~ack);
    assign mask_n    = mask_wr ? iobus.IOBUS_OUT[0] : mask;

    // Low address bits and upper write-data bits carry no meaning here
    logic unused_bits;
    assign unused_bits = &{1'b0, iobus.IOBUS_ADDR[1:0], iobus.IOBUS_OUT[31:16]};

    // Register file; a COUNT write wins over a coincident event
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            pending <= 1'b0;
            mask    <= 1'b0;
            count   <= 16'h0000;
            LEDS    <= 16'h0000;
        end else begin
            pending <= pending_n;
            mask    <= mask_n;
            if (cnt_clr)
                count <= 16'h0000;
            else if (evt)
                count <= count + 16'h0001;
            if (leds_wr)
                LEDS <= iobus.IOBUS_OUT[15:0];
        end
    end

`ifdef INTR_ONESHOT_EN
    // One-cycle pulse on a fresh event, or when a pending request is unmasked
    always_ff @(posedge clk or posedge RST) begin
        if (RST)
            INTR <= 1'b0;
        else
            INTR <= mask_n & (evt | (~mask & pending));
    end
`else
    // Level request tracking next-state pending & mask so ack/unmask act on the same edge
    always_ff @(posedge clk or posedge RST) begin
        if (RST)
            INTR <= 1'b0;
        else
            INTR <= pending_n & mask_n;
    end
`endif

    // Combinational read mux, a function of the address only
    always_comb begin
        iobus.IOBUS_IN = 32'h0;
        if (hit) begin
            case (off)
                OFF_STATUS: iobus.IOBUS_IN = {31'b0, pending};
                OFF_COUNT:  iobus.IOBUS_IN = {16'b0, count};
                OFF_MASK:   iobus.IOBUS_IN = {31'b0, mask};
                OFF_SWITCH: iobus.IOBUS_IN = {16'b0, SW};
                OFF_LEDS:   iobus.IOBUS_IN = {16'b0, LEDS};
                default:    iobus.IOBUS_IN = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Directed self-checking bench for otter_intr_ctrl (DEBOUNCE_CYCLES=4).
module tb_otter_intr_ctrl;
    localparam logic [31:0] B = 32'h11000000;

    logic        clk = 1'b0;
    logic        RST;
    logic        BTN;
    logic [15:0] SW;
    logic        INTR;
    logic [15:0] LEDS;
    int          n_assert = 0;
    int          n_fail   = 0;

    otter_intr_ctrl_if bus();

    otter_intr_ctrl #(.DEBOUNCE_CYCLES(4), .BASE_ADDR(B)) dut (
        .clk   (clk),
        .RST   (RST),
        .BTN   (BTN),
        .SW    (SW),
        .iobus (bus),
        .INTR  (INTR),
        .LEDS  (LEDS)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.IOBUS_ADDR = a;
        #1;
        chk(tag, bus.IOBUS_IN, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.IOBUS_ADDR = a;
        bus.IOBUS_OUT  = d;
        bus.IOBUS_WR   = 1'b1;
        @(negedge clk);
        bus.IOBUS_WR   = 1'b0;
    endtask

    task automatic press(input int hold);
        @(negedge clk);
        BTN = 1'b1;
        repeat (hold) @(negedge clk);
        BTN = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        RST = 1'b1; BTN = 1'b0; SW = 16'hFEED;
        bus.IOBUS_ADDR = 32'h0; bus.IOBUS_OUT = 32'h0; bus.IOBUS_WR = 1'b0;

        // Reset state
        #6;
        chk("rst_intr", {31'b0, INTR}, 32'h0);
        chk("rst_leds", {16'b0, LEDS}, 32'h0);
        chk_rd("rst_count", B + 32'h4, 32'h0);
        chk_rd("rst_switch", B + 32'hC, 32'h0000FEED);
        #33;
        RST = 1'b0;

        // Clean press with mask=1: INTR rises on the 7th edge after BTN
        wr(B + 32'h8, 32'h1);
        @(negedge clk);
        BTN = 1'b1;
        repeat (6) @(negedge clk);
        chk("press_intr_e6", {31'b0, INTR}, 32'h0);
        @(negedge clk);
        chk("press_intr_e7", {31'b0, INTR}, 32'h1);
        repeat (13) @(negedge clk);
        BTN = 1'b0;
        repeat (10) @(negedge clk);
        chk_rd("press_count", B + 32'h4, 32'h1);
        chk_rd("press_status", B, 32'h1);
        wr(B, 32'h0);
        chk_rd("ack0_status", B, 32'h1);
        wr(B, 32'h1);
        chk("ack_intr", {31'b0, INTR}, 32'h0);
        chk_rd("ack_status", B, 32'h0);

        // COUNT write clears, then bounce yields nothing
        wr(B + 32'h4, 32'h1234);
        chk_rd("cnt_clear", B + 32'h4, 32'h0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            BTN = 1'b1;
            repeat (3) @(negedge clk);
            BTN = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk_rd("bounce_count", B + 32'h4, 32'h0);
        chk_rd("bounce_status", B, 32'h0);
        chk("bounce_intr", {31'b0, INTR}, 32'h0);

        // Masked press: pends and counts, INTR only after unmask
        wr(B + 32'h8, 32'h0);
        press(10);
        chk("mask_intr", {31'b0, INTR}, 32'h0);
        chk_rd("mask_status", B, 32'h1);
        chk_rd("mask_count", B + 32'h4, 32'h1);
        wr(B + 32'h8, 32'hFFFF_FFFF);
        chk("unmask_intr", {31'b0, INTR}, 32'h1);
        chk_rd("mask_read", B + 32'h8, 32'h1);
        wr(B, 32'h1);
        chk("mask_ack_intr", {31'b0, INTR}, 32'h0);

        // Count wrap plus ack on the exact event cycle
        @(negedge clk);
        force dut.count = 16'hFFFF;
        @(negedge clk);
        release dut.count;
        chk_rd("preset_count", B + 32'h4, 32'h0000FFFF);
        @(negedge clk);
        BTN = 1'b1;
        repeat (6) @(negedge clk);
        bus.IOBUS_ADDR = B; bus.IOBUS_OUT = 32'h1; bus.IOBUS_WR = 1'b1;
        @(negedge clk);
        bus.IOBUS_WR = 1'b0;
        chk_rd("coll_ack_status", B, 32'h1);
        chk("coll_ack_intr", {31'b0, INTR}, 32'h1);
        chk_rd("wrap_count", B + 32'h4, 32'h0);
        BTN = 1'b0;
        repeat (10) @(negedge clk);
        wr(B, 32'h1);

        // COUNT write on the exact event cycle wins
        @(negedge clk);
        BTN = 1'b1;
        repeat (6) @(negedge clk);
        bus.IOBUS_ADDR = B + 32'h4; bus.IOBUS_OUT = 32'h0; bus.IOBUS_WR = 1'b1;
        @(negedge clk);
        bus.IOBUS_WR = 1'b0;
        chk_rd("coll_cnt_count", B + 32'h4, 32'h0);
        chk_rd("coll_cnt_status", B, 32'h1);
        BTN = 1'b0;
        repeat (10) @(negedge clk);
        wr(B, 32'h1);
        wr(B + 32'h10, 32'h0000_5A5A);

        // Reset in the middle of RISE_WAIT with BTN held
        @(negedge clk);
        BTN = 1'b1;
        repeat (3) @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
        chk("mid_rst_intr", {31'b0, INTR}, 32'h0);
        chk("mid_rst_leds", {16'b0, LEDS}, 32'h0);
        @(negedge clk);
        RST = 1'b0;
        repeat (6) @(negedge clk);
        chk_rd("mid_cnt_e6", B + 32'h4, 32'h0);
        @(negedge clk);
        chk_rd("mid_cnt_e7", B + 32'h4, 32'h1);
        chk_rd("mid_status", B, 32'h1);
        chk("mid_intr_masked", {31'b0, INTR}, 32'h0);
        repeat (20) @(negedge clk);
        BTN = 1'b0;
        repeat (10) @(negedge clk);
        chk_rd("mid_cnt_final", B + 32'h4, 32'h1);

        // LEDS register, address aliasing, unmapped and miss accesses
        wr(B + 32'h10, 32'hABCD1234);
        chk("leds_out", {16'b0, LEDS}, 32'h00001234);
        chk_rd("leds_read", B + 32'h10, 32'h00001234);
        chk_rd("leds_alias", B + 32'h13, 32'h00001234);
        chk_rd("unmapped_rd", B + 32'h14, 32'h0);
        chk_rd("miss_rd", 32'h12000010, 32'h0);
        wr(32'h12000010, 32'h0000FFFF);
        chk("miss_wr_leds", {16'b0, LEDS}, 32'h00001234);
        wr(B + 32'hC, 32'h0000_0000);
        chk_rd("switch_ro", B + 32'hC, 32'h0000FEED);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
